// File: rtl/bp_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_arbiter
// Brief    : Arbitrates the single BTB/predictor table port between fetch
//            lookups and buffered commit-time training updates. It has a
//            starvation-forced write and a drain mode.
// Revision : 1.0  initial release
// ============================================================================
module bp_update_arbiter #(
    parameter int SIZE_PC      = 32,
    parameter int BRANCH_TYPE  = 2,
    parameter int UPD_Q_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          updateEn_i,
    input  logic [SIZE_PC-1:0]            updatePC_i,
    input  logic [SIZE_PC-1:0]            updateNPC_i,
    input  logic [BRANCH_TYPE-1:0]        updateCtrlType_i,
    input  logic                          updateDir_i,
    input  logic [1:0]                    updateCounter_i,
    output logic                          updateFull_o,
    input  logic                          fetchReq_i,
    output logic                          fetchGrant_o,
    output logic                          fetchHold_o,
    input  logic                          drainReq_i,
    output logic                          drainDone_o,
    output logic                          tblWrEn_o,
    output logic [SIZE_PC-1:0]            tblWrPC_o,
    output logic [SIZE_PC-1:0]            tblWrNPC_o,
    output logic [BRANCH_TYPE-1:0]        tblWrType_o,
    output logic                          tblWrDir_o,
    output logic [1:0]                    tblWrCounter_o,
    output logic [$clog2(UPD_Q_DEPTH):0]  qCount_o
);

    localparam int c_PTR_W = $clog2(UPD_Q_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int c_ENT_W = 2 * SIZE_PC + BRANCH_TYPE + 3;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(UPD_Q_DEPTH);
    localparam logic [c_STV_W-1:0] c_LIMIT = c_STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FORCE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_ENT_W-1:0]   r_mem [UPD_Q_DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_STV_W-1:0]   r_starve;
    logic [c_STV_W-1:0]   w_starve_nxt;
    logic                 w_nonempty;
    logic                 w_enq;
    logic                 w_deq;
    logic                 w_drain_done;
    logic [c_ENT_W-1:0]   w_head;

    // Entries are only accepted while there is room; an update offered while
    // full is dropped without disturbing any state.
    assign w_nonempty = (r_count != '0);
    assign w_enq      = reset & updateEn_i & (r_count != c_DEPTH);
    assign w_head     = reset ? r_mem[r_rd_ptr] : '0;

    // Next-state, dequeue decision and starvation-count update.
    always_comb begin
        w_state_nxt  = r_state;
        w_deq        = 1'b0;
        w_starve_nxt = '0;
        w_drain_done = 1'b0;
        if (reset) begin
            case (r_state)
                S_IDLE: begin
                    w_deq = w_nonempty & ~fetchReq_i;
                    if (w_nonempty & fetchReq_i) begin
                        w_starve_nxt = (r_starve == c_LIMIT) ? r_starve
                                                             : r_starve + c_STV_W'(1);
                    end
                    if (drainReq_i) begin
                        w_state_nxt  = S_DRAIN;
                        w_starve_nxt = '0;
                    end else if (w_starve_nxt == c_LIMIT) begin
                        w_state_nxt = S_FORCE;
                    end
                end
                S_FORCE: begin
                    w_deq       = w_nonempty;
                    w_state_nxt = drainReq_i ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    w_deq = w_nonempty;
                    if (!w_nonempty) begin
                        w_drain_done = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, pointers, occupancy and starvation counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            if (w_enq) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Update storage; no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= {updatePC_i, updateNPC_i, updateCtrlType_i,
                                updateDir_i, updateCounter_i};
        end
    end

    // Port ownership: every output is forced low while reset is held.
    assign tblWrEn_o    = w_deq;
    assign fetchGrant_o = reset & fetchReq_i & ~w_deq & (r_state != S_DRAIN);
    assign fetchHold_o  = reset & fetchReq_i & (w_deq | (r_state == S_DRAIN));
    assign drainDone_o  = w_drain_done;
    assign updateFull_o = reset & (r_count == c_DEPTH);
    assign qCount_o     = reset ? r_count : '0;
    assign {tblWrPC_o, tblWrNPC_o, tblWrType_o, tblWrDir_o, tblWrCounter_o} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_arbiter
// Brief    : Self-checking bench for bp_update_arbiter with a queue-based
//            reference model of the port-sharing rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_update_arbiter;

    localparam int LIMIT    = 8;
    localparam int DEPTH    = 4;
    localparam int M_NORMAL = 0;
    localparam int M_FORCED = 1;
    localparam int M_DRAIN  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        updateEn_i = 1'b0;
    logic [31:0] updatePC_i = '0;
    logic [31:0] updateNPC_i = '0;
    logic [1:0]  updateCtrlType_i = '0;
    logic        updateDir_i = 1'b0;
    logic [1:0]  updateCounter_i = '0;
    logic        fetchReq_i = 1'b0;
    logic        drainReq_i = 1'b0;
    logic        updateFull_o, fetchGrant_o, fetchHold_o, drainDone_o, tblWrEn_o;
    logic [31:0] tblWrPC_o, tblWrNPC_o;
    logic [1:0]  tblWrType_o, tblWrCounter_o;
    logic        tblWrDir_o;
    logic [2:0]  qCount_o;

    always #5 clk = ~clk;

    bp_update_arbiter #(
        .SIZE_PC(32), .BRANCH_TYPE(2), .UPD_Q_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .updateEn_i(updateEn_i), .updatePC_i(updatePC_i), .updateNPC_i(updateNPC_i),
        .updateCtrlType_i(updateCtrlType_i), .updateDir_i(updateDir_i),
        .updateCounter_i(updateCounter_i), .updateFull_o(updateFull_o),
        .fetchReq_i(fetchReq_i), .fetchGrant_o(fetchGrant_o), .fetchHold_o(fetchHold_o),
        .drainReq_i(drainReq_i), .drainDone_o(drainDone_o),
        .tblWrEn_o(tblWrEn_o), .tblWrPC_o(tblWrPC_o), .tblWrNPC_o(tblWrNPC_o),
        .tblWrType_o(tblWrType_o), .tblWrDir_o(tblWrDir_o),
        .tblWrCounter_o(tblWrCounter_o), .qCount_o(qCount_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [1:0]  typ;
        logic        dir;
        logic [1:0]  ctr;
    } ent_t;

    ent_t mq[$];
    int   m_starve = 0;
    int   m_mode = M_NORMAL;
    logic e_wr, e_grant, e_hold, e_done, e_full;
    int   e_cnt;
    ent_t e_data;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;

    // Expected outputs for the current cycle from the model and current inputs.
    task automatic model_outputs();
        e_wr = 0; e_grant = 0; e_hold = 0; e_done = 0; e_full = 0; e_cnt = 0; e_data = '0;
        if (reset) begin
            e_cnt  = mq.size();
            e_full = (e_cnt == DEPTH);
            if (e_cnt > 0) e_data = mq[0];
            case (m_mode)
                M_NORMAL: e_wr = (e_cnt > 0) && !fetchReq_i;
                M_FORCED: e_wr = (e_cnt > 0);
                default: begin
                    e_wr   = (e_cnt > 0);
                    e_done = (e_cnt == 0);
                end
            endcase
            e_grant = fetchReq_i && !e_wr && (m_mode != M_DRAIN);
            e_hold  = fetchReq_i && !e_grant;
        end
    endtask

    // Advance the model across a clock edge.
    task automatic model_commit();
        ent_t in;
        if (!reset) begin
            mq.delete();
            m_starve = 0;
            m_mode   = M_NORMAL;
            return;
        end
        in = {updatePC_i, updateNPC_i, updateCtrlType_i, updateDir_i, updateCounter_i};
        if (e_wr) void'(mq.pop_front());
        if (updateEn_i && e_cnt < DEPTH) mq.push_back(in);
        case (m_mode)
            M_NORMAL: begin
                if (e_cnt > 0 && fetchReq_i) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
                else m_starve = 0;
                if (drainReq_i) begin
                    m_mode   = M_DRAIN;
                    m_starve = 0;
                end else if (m_starve == LIMIT) begin
                    m_mode = M_FORCED;
                end
            end
            M_FORCED: begin
                m_starve = 0;
                m_mode   = drainReq_i ? M_DRAIN : M_NORMAL;
            end
            default: if (e_done) m_mode = M_NORMAL;
        endcase
    endtask

    task automatic settle(input logic rst, input logic en, input logic fr, input logic dr);
        @(negedge clk);
        reset            = rst;
        updateEn_i       = en;
        fetchReq_i       = fr;
        drainReq_i       = dr;
        updatePC_i       = $urandom;
        updateNPC_i      = $urandom;
        updateCtrlType_i = 2'($urandom);
        updateDir_i      = 1'($urandom);
        updateCounter_i  = 2'($urandom);
        #1;
        model_outputs();
        cyc++;
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
    endtask

    function automatic logic [76:0] act_vec();
        return {tblWrEn_o, fetchGrant_o, fetchHold_o, drainDone_o, updateFull_o, qCount_o,
                tblWrEn_o ? {tblWrPC_o, tblWrNPC_o, tblWrType_o, tblWrDir_o, tblWrCounter_o}
                          : 69'b0};
    endfunction

    function automatic logic [76:0] exp_vec();
        return {e_wr, e_grant, e_hold, e_done, e_full, 3'(e_cnt), e_wr ? e_data : 69'b0};
    endfunction

    task automatic test_reset();
        ent_t saved;
        for (int i = 0; i < 3; i++) begin
            settle(0, 1, 1'($urandom), 0);
            n_chk++;
            if ({act_vec(), tblWrPC_o, tblWrNPC_o, tblWrType_o, tblWrDir_o, tblWrCounter_o}
                !== {exp_vec(), 69'b0})
                $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            else n_pass++;
            advance();
        end
        settle(1, 1, 0, 0);
        saved = {updatePC_i, updateNPC_i, updateCtrlType_i, updateDir_i, updateCounter_i};
        n_chk++;
        if (act_vec() !== exp_vec())
            $display("FAIL no_bypass cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
        else n_pass++;
        advance();
        settle(1, 0, 0, 0);
        n_chk++;
        if ({tblWrEn_o, tblWrPC_o, tblWrNPC_o, tblWrType_o, tblWrDir_o, tblWrCounter_o}
            !== {1'b1, saved})
            $display("FAIL single_write got=%b/%h exp=1/%h", tblWrEn_o, tblWrPC_o, saved);
        else n_pass++;
        advance();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            settle(1, 1, 1, 0);
            n_chk++;
            if (act_vec() !== exp_vec())
                $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            else n_pass++;
            advance();
        end
        settle(1, 0, 1, 0);
        n_chk++;
        if ({updateFull_o, qCount_o, tblWrEn_o, fetchGrant_o} !== {1'b1, 3'd4, 1'b0, 1'b1})
            $display("FAIL full_flag got=%b/%0d/%b exp=1/4/0", updateFull_o, qCount_o, tblWrEn_o);
        else n_pass++;
        advance();
    endtask

    task automatic test_starvation();
        int writes = 0;
        int gap = 0;
        int enq = 0;
        bit seen = 0;
        bit en;
        for (int i = 0; i < 150 && writes < 10; i++) begin
            en = (mq.size() < DEPTH) && (enq < 6);
            settle(1, en, 1, 0);
            if (en) enq++;
            n_chk++;
            if (act_vec() !== exp_vec())
                $display("FAIL starve cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            else n_pass++;
            if (tblWrEn_o) begin
                if (seen) begin
                    n_chk++;
                    if (gap != LIMIT || fetchHold_o !== 1'b1)
                        $display("FAIL starve_gap got=%0d exp=%0d", gap, LIMIT);
                    else n_pass++;
                end
                seen = 1; gap = 0; writes++;
            end else if (fetchGrant_o) begin
                gap++;
            end
            advance();
        end
        n_chk++;
        if (writes != 10) $display("FAIL starve_timeout got=%0d writes exp=10", writes);
        else n_pass++;
    endtask

    task automatic test_drain();
        logic [3:0] pat [5] = '{4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            settle(1, (i < 3), 1, (i == 3));
            n_chk++;
            if (act_vec() !== exp_vec())
                $display("FAIL drain_setup cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            else n_pass++;
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            settle(1, 0, 1, 0);
            n_chk++;
            if ({tblWrEn_o, fetchHold_o, drainDone_o, fetchGrant_o} !== pat[i] ||
                act_vec() !== exp_vec())
                $display("FAIL drain_seq step=%0d got=%b exp=%b", i,
                         {tblWrEn_o, fetchHold_o, drainDone_o, fetchGrant_o}, pat[i]);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_drain_empty();
        int writes = 0;
        bit done = 0;
        settle(1, 0, 0, 1);
        advance();
        settle(1, 0, 0, 0);
        n_chk++;
        if ({drainDone_o, tblWrEn_o} !== 2'b10 || act_vec() !== exp_vec())
            $display("FAIL drain_empty got=%b exp=10", {drainDone_o, tblWrEn_o});
        else n_pass++;
        advance();
        for (int i = 0; i < 3; i++) begin
            settle(1, (i < 2), 1, (i == 2));
            advance();
        end
        for (int i = 0; i < 10 && !done; i++) begin
            settle(1, (i == 0), 0, 0);
            n_chk++;
            if (act_vec() !== exp_vec())
                $display("FAIL drain_extend cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            else n_pass++;
            if (tblWrEn_o) writes++;
            if (drainDone_o) done = 1;
            advance();
        end
        n_chk++;
        if (!done || writes != 3)
            $display("FAIL drain_extend_count got=%0d writes done=%b exp=3 done=1", writes, done);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            settle(1, (i < 2), 1, (i == 2));
            advance();
        end
        settle(0, 0, 1, 0);
        n_chk++;
        if (act_vec() !== 77'b0)
            $display("FAIL mid_drain_reset got=%h exp=0", act_vec());
        else n_pass++;
        advance();
        for (int i = 0; i < 3; i++) begin
            settle(1, 0, 1, 0);
            n_chk++;
            if ({fetchGrant_o, fetchHold_o, tblWrEn_o, drainDone_o, qCount_o}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0} || act_vec() !== exp_vec())
                $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            settle(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
                   ($urandom_range(0, 29) == 0));
            n_chk++;
            if (act_vec() !== exp_vec())
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            else n_pass++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_starvation();
        test_drain();
        test_drain_empty();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
